// File: rtl/matmul_scratchpad.sv
// matmul_scratchpad: result scratchpad behind the matmul calc stage.
// The block collects the C element write burst and commits it as one
// complete matrix into one of SP_NTARGETS slots. It serves a registered
// bias read port and a host read port, and it flags which slots are valid.
// Build option: define SP_BYPASS_EN to forward same-cycle write data to the
// bias read port. When it is undefined, the bias port is read-first.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// S_IDLE   | no burst open; the first accepted write opens one
// S_FILL   | burst open; writes land in the latched target slot
// S_COMMIT | one cycle; a full mask sets valid, otherwise err is raised
module matmul_scratchpad #(
  parameter int DATA_WIDTH  = 8,
  parameter int BUS_WIDTH   = 16,
  parameter int ADDR_WIDTH  = 32,
  parameter int SP_NTARGETS = 4,
  localparam int MAX_DIM = BUS_WIDTH / DATA_WIDTH,
  localparam int ELEMS   = MAX_DIM * MAX_DIM,
  localparam int IDXW    = 2 * $clog2(MAX_DIM),
  localparam int TW      = $clog2(SP_NTARGETS)
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   enable_w_i,
  input  logic [ADDR_WIDTH-1:0]  address_i,
  input  logic [BUS_WIDTH-1:0]   data_i,
  input  logic [TW-1:0]          write_target_i,
  input  logic                   finish_mul_i,
  input  logic [TW-1:0]          read_target_i,
  input  logic [ADDR_WIDTH-1:0]  address_c_i,
  output logic [BUS_WIDTH-1:0]   data_c_o,
  input  logic                   host_rd_i,
  input  logic [TW-1:0]          host_target_i,
  input  logic [IDXW-1:0]        host_idx_i,
  output logic [BUS_WIDTH-1:0]   host_data_o,
  output logic                   host_valid_o,
  output logic [SP_NTARGETS-1:0] valid_o,
  output logic                   err_o,
  input  logic                   err_clr_i
);

  localparam logic [4:0]      OP_C    = 5'b10000;
  localparam logic [IDXW:0]   ELEMS_W = (IDXW+1)'(ELEMS);

  typedef enum logic [1:0] {S_IDLE, S_FILL, S_COMMIT} state_t;

  state_t state_q, state_d;

  logic [BUS_WIDTH-1:0]   mem [SP_NTARGETS][ELEMS];
  logic [ELEMS-1:0]       mask_q, mask_d;
  logic [TW-1:0]          tgt_q;
  logic [SP_NTARGETS-1:0] valid_q;
  logic                   err_q;
  logic [BUS_WIDTH-1:0]   data_c_q;
  logic [BUS_WIDTH-1:0]   host_data_q;
  logic                   host_valid_q;

  logic [IDXW-1:0]  wr_idx, rd_idx;
  logic             wr_accept, wr_reject, start_burst;
  logic             rd_in_range, host_in_range;
  logic [TW-1:0]    wr_tgt;
  logic [ELEMS-1:0] wr_onehot;
  logic             commit_ok, commit_bad;

  logic unused_addr_bits;
  assign unused_addr_bits = ^{address_i[ADDR_WIDTH-1:5+IDXW],
                              address_c_i[ADDR_WIDTH-1:5+IDXW],
                              address_c_i[4:0]};

  assign wr_idx        = address_i[5 +: IDXW];
  assign rd_idx        = address_c_i[5 +: IDXW];
  assign rd_in_range   = {1'b0, rd_idx} < ELEMS_W;
  assign host_in_range = {1'b0, host_idx_i} < ELEMS_W;
  assign wr_accept     = enable_w_i && (address_i[4:0] == OP_C) &&
                         ({1'b0, wr_idx} < ELEMS_W);
  assign wr_reject     = enable_w_i && !wr_accept;
  // A write outside FILL (in IDLE or COMMIT) opens a new burst.
  assign start_burst   = wr_accept && (state_q != S_FILL);
  assign wr_tgt        = (state_q == S_FILL) ? tgt_q : write_target_i;
  assign wr_onehot     = {{(ELEMS-1){1'b0}}, 1'b1} << wr_idx;
  assign commit_ok     = (state_q == S_COMMIT) && (&mask_q);
  assign commit_bad    = (state_q == S_COMMIT) && !(&mask_q);

  // Next-state and next-mask logic for the burst FSM.
  always_comb begin
    state_d = state_q;
    mask_d  = mask_q;
    case (state_q)
      S_IDLE: begin
        if (wr_accept) begin
          state_d = S_FILL;
          mask_d  = wr_onehot;
        end
      end
      S_FILL: begin
        if (wr_accept) mask_d = mask_q | wr_onehot;
        if (finish_mul_i) state_d = S_COMMIT;
      end
      S_COMMIT: begin
        if (wr_accept) begin
          state_d = S_FILL;
          mask_d  = wr_onehot;
        end else begin
          state_d = S_IDLE;
          mask_d  = '0;
        end
      end
      default: begin
        state_d = S_IDLE;
        mask_d  = '0;
      end
    endcase
  end

  // FSM state, written-mask and latched target registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      mask_q  <= '0;
      tgt_q   <= '0;
    end else begin
      state_q <= state_d;
      mask_q  <= mask_d;
      if (start_burst) tgt_q <= write_target_i;
    end
  end

  // Per-slot valid flags. A burst that reopens a slot clears its flag,
  // and this clear overrides a commit to the same slot on the same edge.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q <= '0;
    end else begin
      if (commit_ok) valid_q[tgt_q] <= 1'b1;
      if (start_burst) valid_q[write_target_i] <= 1'b0;
    end
  end

  // Sticky error flag. A new error wins over a clear on the same edge.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) err_q <= 1'b0;
    else         err_q <= (err_q && !err_clr_i) || wr_reject || commit_bad;
  end

  // Element storage.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int t = 0; t < SP_NTARGETS; t++)
        for (int e = 0; e < ELEMS; e++)
          mem[t][e] <= '0;
    end else if (wr_accept) begin
      mem[wr_tgt][wr_idx] <= data_i;
    end
  end

  // Registered bias read port, sampled every cycle.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      data_c_q <= '0;
    end else begin
`ifdef SP_BYPASS_EN
      if (wr_accept && (wr_tgt == read_target_i) && (wr_idx == rd_idx))
        data_c_q <= data_i;
      else
        data_c_q <= rd_in_range ? mem[read_target_i][rd_idx] : '0;
`else
      data_c_q <= rd_in_range ? mem[read_target_i][rd_idx] : '0;
`endif
    end
  end

  // Host read port: one-cycle response, and data holds between requests.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      host_valid_q <= 1'b0;
      host_data_q  <= '0;
    end else begin
      host_valid_q <= host_rd_i;
      if (host_rd_i)
        host_data_q <= host_in_range ? mem[host_target_i][host_idx_i] : '0;
    end
  end

  assign data_c_o     = data_c_q;
  assign host_data_o  = host_data_q;
  assign host_valid_o = host_valid_q;
  assign valid_o      = valid_q;
  assign err_o        = err_q;

endmodule
